// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a registered valid/ready fetch port.
// Each accepted fetch returns its word one cycle later. A branch flush drops the held response.
module instr_fetch_mem #(
  parameter int                 ADDR_W  = 8,
  parameter int                 INSTR_W = 16,
  parameter int                 DEPTH   = 256,
  parameter logic [INSTR_W-1:0] NOP     = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ld_en_i,
  input  logic [ADDR_W-1:0]  ld_addr_i,
  input  logic [INSTR_W-1:0] ld_data_i,
  input  logic               flush_i,
  input  logic               req_valid_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  output logic               req_ready_o,
  output logic               rsp_valid_o,
  output logic [INSTR_W-1:0] rsp_instr_o,
  output logic [ADDR_W-1:0]  rsp_addr_o,
  output logic               rsp_err_o,
  input  logic               rsp_ready_i
);

  // Index width covers DEPTH words. One extra bit on the limit lets DEPTH == 2**ADDR_W fit.
  localparam int                IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DepthC = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   rspInstr_q, rspInstr_d;
  logic [ADDR_W-1:0]    rspAddr_q, rspAddr_d;
  logic                 rspErr_q, rspErr_d;

  logic [INSTR_W-1:0]   mem_q [DEPTH];

  logic                 ldInRange;
  logic                 reqInRange;
  logic [IdxW-1:0]      ldIdx;
  logic [IdxW-1:0]      reqIdx;
  logic [INSTR_W-1:0]   memRead;
  logic                 accept;

  assign ldInRange  = {1'b0, ld_addr_i}  < DepthC;
  assign reqInRange = {1'b0, req_addr_i} < DepthC;
  assign ldIdx      = ld_addr_i[IdxW-1:0];
  assign reqIdx     = req_addr_i[IdxW-1:0];
  assign memRead    = mem_q[reqIdx];

  // Loads block fetches, so a word is never read and written in the same cycle.
  assign req_ready_o = !ld_en_i && !flush_i && ((state_q == EMPTY) || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // The program array has no reset; its contents persist across rst_i.
  always_ff @(posedge clk_i) begin
    if (ld_en_i && ldInRange) begin
      mem_q[ldIdx] <= ld_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    rspInstr_d = rspInstr_q;
    rspAddr_d  = rspAddr_q;
    rspErr_d   = rspErr_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d    = FULL;
      rspAddr_d  = req_addr_i;
      rspErr_d   = !reqInRange;
      rspInstr_d = reqInRange ? memRead : NOP;
    end else if ((state_q == FULL) && rsp_ready_i) begin
      // Consumed with nothing behind it: payload is left in place, only valid drops.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      rspInstr_q <= NOP;
      rspAddr_q  <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rspInstr_q <= rspInstr_d;
      rspAddr_q  <= rspAddr_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_instr_o = rspInstr_q;
  assign rsp_addr_o  = rspAddr_q;
  assign rsp_err_o   = rspErr_q;

endmodule
